// File: rtl/toy_mem_pkg.sv
// Shared types for the RISC_TOY memory arbiter: FSM states, access direction
// and grant encoding, plus the fixed-priority grant rule.
package toy_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Data port wins unless fetch has been starved for the maximum streak.
    function automatic grant_t sel_grant(input logic i_req, input logic d_req,
                                         input logic starved);
        grant_t g;
        if (d_req && !(i_req && starved)) begin
            g = GNT_D;
        end else begin
            g = GNT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/toy_arb_prio.sv
// Grant selection with a starvation guard: counts consecutive data grants
// taken while a fetch was waiting and forces the fetch once the limit is hit.
module toy_arb_prio
    import toy_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   CLK,
    input  logic   RSTN,
    input  logic   I_REQ,
    input  logic   D_REQ,
    input  logic   GNT_STB,
    output grant_t GRANT
);

    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] streak_r;
    logic          starved_s;

    // Combinational grant decision from the current streak.
    always_comb begin
        starved_s = (streak_r == SW'(STARVE_MAX));
        GRANT     = sel_grant(I_REQ, D_REQ, starved_s);
    end

    // Streak update on every grant; saturates at the starvation limit.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            streak_r <= '0;
        end else if (GNT_STB) begin
            if ((GRANT == GNT_D) && I_REQ) begin
                if (!starved_s) begin
                    streak_r <= streak_r + SW'(1);
                end
            end else begin
                streak_r <= '0;
            end
        end
    end

endmodule

// File: rtl/toy_mem_arbiter.sv
// Serialises RISC_TOY fetch and data accesses onto one single-port memory,
// one transaction at a time, with registered ACK pulses and read data.
module toy_mem_arbiter
    import toy_mem_pkg::*;
#(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_ACK,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_RW,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_ACK,
    output logic [DW-1:0] D_RDATA,
    output logic          M_REQ,
    output logic          M_RW,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic [DW-1:0] M_RDATA
);

    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state_r;
    grant_t        own_r;
    logic [WW-1:0] wcnt_r;
    grant_t        grant_s;
    logic          gnt_stb_s;

    // Inputs are only sampled in IDLE; that is also when the streak advances.
    always_comb begin
        gnt_stb_s = (state_r == ST_IDLE) && (I_REQ || D_REQ);
    end

    toy_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .I_REQ   (I_REQ),
        .D_REQ   (D_REQ),
        .GNT_STB (gnt_stb_s),
        .GRANT   (grant_s)
    );

    // Transaction FSM with all memory-side and core-side outputs registered.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
            own_r   <= GNT_I;
            wcnt_r  <= '0;
            M_REQ   <= 1'b0;
            M_RW    <= RW_READ;
            M_ADDR  <= '0;
            M_WDATA <= '0;
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
            I_RDATA <= '0;
            D_RDATA <= '0;
        end else begin
            M_REQ <= 1'b0;
            I_ACK <= 1'b0;
            D_ACK <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_stb_s) begin
                        own_r   <= grant_s;
                        M_REQ   <= 1'b1;
                        state_r <= ST_ISSUE;
                        if (grant_s == GNT_D) begin
                            M_RW   <= D_RW;
                            M_ADDR <= D_ADDR;
                            // Write data only matters for writes; reads keep the old value.
                            if (D_RW == RW_WRITE) begin
                                M_WDATA <= D_WDATA;
                            end
                        end else begin
                            M_RW   <= RW_READ;
                            M_ADDR <= I_ADDR;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (M_RW == RW_WRITE) begin
                        D_ACK   <= (own_r == GNT_D);
                        I_ACK   <= (own_r == GNT_I);
                        state_r <= ST_DONE;
                    end else begin
                        wcnt_r  <= WW'(MEM_LAT - 1);
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_r == '0) begin
                        if (own_r == GNT_D) begin
                            D_RDATA <= M_RDATA;
                            D_ACK   <= 1'b1;
                        end else begin
                            I_RDATA <= M_RDATA;
                            I_ACK   <= 1'b1;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        wcnt_r <= wcnt_r - WW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Directed scoreboard bench for toy_mem_arbiter: a behavioural memory with
// MEM_LAT read latency, plus a MEM_LAT=1 instance for the short-latency case.
module tb_toy_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MEM_LAT = 2;
    localparam int STARVE_MAX = 4;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          I_REQ, D_REQ, D_RW;
    logic [AW-1:0] I_ADDR, D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          I_ACK, D_ACK, M_REQ, M_RW;
    logic [DW-1:0] I_RDATA, D_RDATA, M_WDATA, M_RDATA;
    logic [AW-1:0] M_ADDR;

    logic          l1_i_req, l1_i_ack, l1_d_ack, l1_m_req, l1_m_rw;
    logic [AW-1:0] l1_i_addr, l1_m_addr;
    logic [DW-1:0] l1_i_rdata, l1_d_rdata, l1_m_wdata, l1_m_rdata;

    always #5 CLK = ~CLK;

    toy_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
    );

    toy_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_lat1 (
        .CLK(CLK), .RSTN(RSTN),
        .I_REQ(l1_i_req), .I_ADDR(l1_i_addr), .I_ACK(l1_i_ack), .I_RDATA(l1_i_rdata),
        .D_REQ(1'b0), .D_RW(1'b0), .D_ADDR({AW{1'b0}}), .D_WDATA({DW{1'b0}}),
        .D_ACK(l1_d_ack), .D_RDATA(l1_d_rdata),
        .M_REQ(l1_m_req), .M_RW(l1_m_rw), .M_ADDR(l1_m_addr), .M_WDATA(l1_m_wdata),
        .M_RDATA(l1_m_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = DW'(a) ^ 32'h0000_0010;
        return 32'hDEAD_BEEF ^ (x * 32'h0100_0193);
    endfunction

    // Behavioural memory: writes land at the M_REQ edge, read data appears MEM_LAT cycles later.
    logic [DW-1:0] wmem [0:255];
    logic [255:0]  wvld = '0;
    logic [DW-1:0] rpipe [0:MEM_LAT-1];
    always @(posedge CLK) begin
        if (M_REQ && M_RW) begin
            wmem[M_ADDR[7:0]] <= M_WDATA;
            wvld[M_ADDR[7:0]] <= 1'b1;
        end
        rpipe[0] <= (M_REQ && !M_RW) ?
                    (wvld[M_ADDR[7:0]] ? wmem[M_ADDR[7:0]] : init_val(M_ADDR)) : 32'hBAD0_0BAD;
        for (int k = 1; k < MEM_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign M_RDATA = rpipe[MEM_LAT-1];

    always @(posedge CLK) begin
        l1_m_rdata <= (l1_m_req && !l1_m_rw) ? init_val(l1_m_addr) : 32'hBAD1_BAD1;
    end

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t i_stim[$], d_stim[$], i_sb[$], d_sb[$], iss_q[$];
    logic [DW-1:0] ref_w [0:255];
    logic [255:0]  ref_v = '0;
    logic [DW-1:0] i_last, d_last;
    logic          i_ack_seen, d_ack_seen, prev_mreq;
    int            cyc, n_checks, n_fail;

    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
        return ref_v[a[7:0]] ? ref_w[a[7:0]] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        i_ack_seen = I_ACK;
        d_ack_seen = D_ACK;
        check("ack_overlap", 64'(I_ACK & D_ACK), 64'(0));
        check("mreq_pulse", 64'(M_REQ & prev_mreq), 64'(0));
        prev_mreq = M_REQ;
        if (M_REQ) begin
            check("iss_expected", 64'(iss_q.size() > 0), 64'(1));
            if (iss_q.size() > 0) begin
                e = iss_q.pop_front();
                check("m_addr", 64'(M_ADDR), 64'(e.addr));
                check("m_rw", 64'(M_RW), 64'(e.rw));
                if (e.rw) check("m_wdata", 64'(M_WDATA), 64'(e.data));
            end
        end
        if (I_ACK) begin
            check("i_ack_expected", 64'(i_sb.size() > 0), 64'(1));
            if (i_sb.size() > 0) begin
                e = i_sb.pop_front();
                check("i_rdata", 64'(I_RDATA), 64'(e.data));
                check("i_side_d_rdata", 64'(D_RDATA), 64'(d_last));
                if (e.cyc >= 0) check("i_ack_cycle", 64'(cyc), 64'(e.cyc));
                i_last = e.data;
            end
        end
        if (D_ACK) begin
            check("d_ack_expected", 64'(d_sb.size() > 0), 64'(1));
            if (d_sb.size() > 0) begin
                e = d_sb.pop_front();
                if (!e.rw) d_last = e.data;
                check("d_rdata", 64'(D_RDATA), 64'(d_last));
                check("d_side_i_rdata", 64'(I_RDATA), 64'(i_last));
                if (e.cyc >= 0) check("d_ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        mon();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic present_i();
        exp_t s;
        s = i_stim[0];
        I_REQ  = 1'b1;
        I_ADDR = s.addr;
        i_sb.push_back('{1'b0, s.addr, ref_val(s.addr), (s.cyc < 0) ? -1 : cyc + s.cyc});
    endtask

    task automatic present_d();
        exp_t s;
        s = d_stim[0];
        D_REQ   = 1'b1;
        D_RW    = s.rw;
        D_ADDR  = s.addr;
        D_WDATA = s.data;
        if (s.rw) begin
            ref_w[s.addr[7:0]] = s.data;
            ref_v[s.addr[7:0]] = 1'b1;
            d_sb.push_back('{1'b1, s.addr, s.data, (s.cyc < 0) ? -1 : cyc + s.cyc});
        end else begin
            d_sb.push_back('{1'b0, s.addr, ref_val(s.addr), (s.cyc < 0) ? -1 : cyc + s.cyc});
        end
    endtask

    // Presents queued requests, holding each until its ACK and chaining the next one.
    task automatic serve(input int budget);
        int n;
        n = 0;
        if (i_stim.size() > 0) present_i();
        if (d_stim.size() > 0) present_d();
        while ((i_stim.size() > 0 || d_stim.size() > 0) && n < budget) begin
            tick();
            n++;
            if (i_ack_seen && i_stim.size() > 0) begin
                void'(i_stim.pop_front());
                if (i_stim.size() > 0) present_i(); else I_REQ = 1'b0;
            end
            if (d_ack_seen && d_stim.size() > 0) begin
                void'(d_stim.pop_front());
                if (d_stim.size() > 0) present_d(); else D_REQ = 1'b0;
            end
        end
        check("serve_done", 64'(i_stim.size() + d_stim.size() + iss_q.size()), 64'(0));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req"}, 64'(M_REQ), 64'(0));
        check({tag, "_m_rw"}, 64'(M_RW), 64'(0));
        check({tag, "_m_addr"}, 64'(M_ADDR), 64'(0));
        check({tag, "_m_wdata"}, 64'(M_WDATA), 64'(0));
        check({tag, "_i_ack"}, 64'(I_ACK), 64'(0));
        check({tag, "_d_ack"}, 64'(D_ACK), 64'(0));
        check({tag, "_i_rdata"}, 64'(I_RDATA), 64'(0));
        check({tag, "_d_rdata"}, 64'(D_RDATA), 64'(0));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; prev_mreq = 1'b0;
        i_last = '0; d_last = '0; i_ack_seen = 1'b0; d_ack_seen = 1'b0;
        RSTN = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0; D_RW = 1'b0;
        I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
        l1_i_req = 1'b0; l1_i_addr = '0;

        repeat (3) tick();
        check_reset_outputs("reset");
        RSTN = 1'b1;
        tick();

        // Fetch-only read.
        i_stim.push_back('{1'b0, 30'h10, 32'h0, MEM_LAT + 2});
        iss_q.push_back('{1'b0, 30'h10, 32'h0, -1});
        serve(20);
        check("t1_i_rdata_const", 64'(I_RDATA), 64'(32'hDEAD_BEEF));

        // Data write, read-back, then a write that must leave D_RDATA alone.
        d_stim.push_back('{1'b1, 30'h20, 32'h1234_5678, 2});
        iss_q.push_back('{1'b1, 30'h20, 32'h1234_5678, -1});
        serve(20);
        d_stim.push_back('{1'b0, 30'h20, 32'h0, MEM_LAT + 2});
        iss_q.push_back('{1'b0, 30'h20, 32'h0, -1});
        serve(20);
        d_stim.push_back('{1'b1, 30'h21, 32'hA5A5_5A5A, 2});
        iss_q.push_back('{1'b1, 30'h21, 32'hA5A5_5A5A, -1});
        serve(20);

        // Simultaneous requests: data first, fetch after a full read slot.
        d_stim.push_back('{1'b0, 30'h40, 32'h0, MEM_LAT + 2});
        i_stim.push_back('{1'b0, 30'h30, 32'h0, 2 * MEM_LAT + 5});
        iss_q.push_back('{1'b0, 30'h40, 32'h0, -1});
        iss_q.push_back('{1'b0, 30'h30, 32'h0, -1});
        serve(40);

        // Starvation guard: four data grants, then the waiting fetch.
        for (int k = 0; k < 6; k++)
            d_stim.push_back('{1'b1, 30'h50 + 30'(k), 32'h5000_0000 + 32'(k), -1});
        i_stim.push_back('{1'b0, 30'h60, 32'h0, -1});
        i_stim.push_back('{1'b0, 30'h61, 32'h0, -1});
        for (int k = 0; k < 4; k++)
            iss_q.push_back('{1'b1, 30'h50 + 30'(k), 32'h5000_0000 + 32'(k), -1});
        iss_q.push_back('{1'b0, 30'h60, 32'h0, -1});
        iss_q.push_back('{1'b1, 30'h54, 32'h5000_0004, -1});
        iss_q.push_back('{1'b1, 30'h55, 32'h5000_0005, -1});
        iss_q.push_back('{1'b0, 30'h61, 32'h0, -1});
        serve(100);

        // Reset during WAIT: outputs clear at once and the read is never acknowledged.
        i_stim.push_back('{1'b0, 30'h70, 32'h0, -1});
        iss_q.push_back('{1'b0, 30'h70, 32'h0, -1});
        present_i();
        tick();
        tick();
        RSTN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        I_REQ = 1'b0;
        i_stim.delete(); i_sb.delete();
        i_last = '0; d_last = '0;
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (6) tick();
        i_stim.push_back('{1'b0, 30'h71, 32'h0, MEM_LAT + 2});
        iss_q.push_back('{1'b0, 30'h71, 32'h0, -1});
        serve(20);

        // MEM_LAT=1 instance: M_REQ in cycle 1, ACK with data in cycle 3.
        l1_i_addr = 30'h15;
        l1_i_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("l1_m_req", 64'(l1_m_req), 64'(k == 1));
            check("l1_i_ack", 64'(l1_i_ack), 64'(k == 3));
            if (k == 1) check("l1_m_addr", 64'(l1_m_addr), 64'(30'h15));
            if (k == 3) begin
                check("l1_i_rdata", 64'(l1_i_rdata), 64'(init_val(30'h15)));
                l1_i_req = 1'b0;
            end
        end
        check("l1_d_ack", 64'(l1_d_ack), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
